mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, transaction
// owner and latency counter sizing.
package arb_pkg;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  // Wide enough for the largest legal read latency (7).
  localparam int CNT_W = 3;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between fetch and data requests. Fixed data priority by default;
// alternating priority when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
  import arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       last_d,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt[GNT_IF] = last_d;
      gnt[GNT_D]  = ~last_d;
`else
      gnt[GNT_D]  = 1'b1;
`endif
    end else begin
      gnt[GNT_IF] = if_req;
      gnt[GNT_D]  = d_req;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_d;
  assign unused_last_d = last_d;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a unified fixed-latency memory.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is data-port priority.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               last_d;
  logic               run, done, free;
  logic [1:0]         gnt;

  // Outputs are combinational, so reset must also mask them directly.
  assign run  = ~rst;
  assign done = (state_q == ST_WAIT) && (cnt_q == LAT_C);
  assign free = run && ((state_q == ST_IDLE) || done);

  arb_pick u_pick (
    .if_req (if_req & free),
    .d_req  (d_req & free),
    .last_d (last_d),
    .gnt    (gnt)
  );

  always_comb begin
    if_gnt    = gnt[GNT_IF];
    d_gnt     = gnt[GNT_D];
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[GNT_D]) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (gnt[GNT_IF]) begin
      mem_addr  = if_addr;
    end
    if_rvalid = run && done && (owner_q == OWN_IF);
    d_rvalid  = run && done && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
    busy      = run && (state_q == ST_WAIT);
  end

  // The response cycle doubles as an arbitration cycle, so a new grant wins over done.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    if (|gnt) begin
      state_d = ST_WAIT;
      owner_d = gnt[GNT_D] ? OWN_D : OWN_IF;
      cnt_d   = CNT_W'(1);
      we_d    = gnt[GNT_D] & d_we;
    end else if (done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      we_d    = 1'b0;
    end else if (state_q == ST_WAIT) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if (|gnt) last_d_d = gnt[GNT_D];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end

  assign last_d = last_d_q;
`else
  assign last_d = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model and a
// simple behavioural memory that answers reads MEM_LAT cycles after mem_en.
module tb_mem_arbiter;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic         if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [W-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction at most.
  bit          pv = 0;
  int          due = 0;
  bit          p_d = 0, p_we = 0;
  logic [31:0] p_addr = '0;
  bit          last_d = 0;

  // Requester agents: hold a request until it is granted.
  bit          rst_v = 1;
  bit          if_pend = 0, d_pend = 0, d_w = 0;
  logic [31:0] if_a = '0, d_a = '0, d_wd = '0;

  // Behavioural memory.
  logic [31:0] mem_arr [logic [31:0]];
  bit          rd_v [16];
  logic [31:0] rd_a [16];

  function automatic logic [31:0] memf(logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic step();
    bit          resp, free, wi, wd, en_s, we_s;
    logic [31:0] e_rd, addr_s, wd_s;
    int          slot;
    @(negedge clk);
    rst     = rst_v;
    if_req  = if_pend;
    if_addr = if_a;
    d_req   = d_pend;
    d_we    = d_w;
    d_addr  = d_a;
    d_wdata = d_wd;
    slot = cyc % 16;
    if (rd_v[slot]) begin
      mem_rdata  = memf(rd_a[slot]);
      rd_v[slot] = 0;
    end else begin
      mem_rdata = $urandom;
    end

    resp = !rst_v && pv && (due == cyc);
    free = !pv || resp;
    wi = 0;
    wd = 0;
    if (!rst_v && free) begin
      if (if_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_d) wi = 1; else wd = 1;
`else
        wd = 1;
`endif
      end else begin
        wi = if_pend;
        wd = d_pend;
      end
    end
    e_rd = (resp && !p_we) ? memf(p_addr) : 32'h0;

    #1;
    check("if_gnt",    32'(if_gnt),    32'(wi));
    check("d_gnt",     32'(d_gnt),     32'(wd));
    check("mem_en",    32'(mem_en),    32'(wi | wd));
    check("mem_we",    32'(mem_we),    32'(wd & d_w));
    check("mem_addr",  mem_addr,  wi ? if_a : (wd ? d_a : 32'h0));
    check("mem_wdata", mem_wdata, wd ? d_wd : 32'h0);
    check("if_rvalid", 32'(if_rvalid), 32'(resp && !p_d));
    check("if_rdata",  if_rdata,  (resp && !p_d) ? e_rd : 32'h0);
    check("d_rvalid",  32'(d_rvalid),  32'(resp && p_d));
    check("d_rdata",   d_rdata,   (resp && p_d) ? e_rd : 32'h0);
    check("busy",      32'(busy),      32'(!rst_v && pv));
    en_s   = mem_en;
    we_s   = mem_we;
    addr_s = mem_addr;
    wd_s   = mem_wdata;

    @(posedge clk);
    if (en_s && we_s) begin
      mem_arr[addr_s] = wd_s;
    end else if (en_s) begin
      rd_v[(cyc + LAT) % 16] = 1;
      rd_a[(cyc + LAT) % 16] = addr_s;
    end
    if (rst_v) begin
      pv     = 0;
      last_d = 0;
    end else begin
      if (resp) pv = 0;
      if (wi || wd) begin
        pv     = 1;
        due    = cyc + LAT;
        p_d    = wd;
        p_we   = wd && d_w;
        p_addr = wi ? if_a : d_a;
        last_d = wd;
      end
      if (wi) if_pend = 0;
      if (wd) d_pend = 0;
    end
    cyc++;
  endtask

  initial begin
    // Reset state, with requests present to show they are masked.
    rst_v = 1;
    if_pend = 1; if_a = 32'h40;
    step();
    if_pend = 0;
    step();
    rst_v = 0;
    step();

    // Fetch only.
    mem_arr[32'h10] = 32'h0050_0093;
    if_pend = 1; if_a = 32'h10;
    repeat (4) step();

    // Store.
    d_pend = 1; d_w = 1; d_a = 32'h100; d_wd = 32'hDEAD_BEEF;
    repeat (4) step();

    // Simultaneous single requests.
    if_pend = 1; if_a = 32'h20;
    d_pend = 1; d_w = 0; d_a = 32'h100; d_wd = 32'h1234_5678;
    repeat (6) step();

    // Simultaneous continuous requests.
    for (int i = 0; i < 8; i++) begin
      if (!if_pend) begin if_pend = 1; if_a = 32'h200 + 32'(i * 4); end
      if (!d_pend)  begin d_pend = 1; d_w = 0; d_a = 32'h300 + 32'(i * 4); end
      step();
    end
    while (if_pend || d_pend) step();
    repeat (3) step();

    // Reset during an outstanding fetch.
    if_pend = 1; if_a = 32'h10;
    step();
    rst_v = 1;
    step();
    rst_v = 0;
    d_pend = 1; d_w = 0; d_a = 32'h10;
    repeat (4) step();

    // Data request arriving while a fetch is outstanding.
    if_pend = 1; if_a = 32'h44;
    step();
    d_pend = 1; d_w = 0; d_a = 32'h80;
    repeat (5) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (!if_pend && $urandom_range(2) == 0) begin
        if_pend = 1;
        if_a = $urandom & 32'h0000_03FC;
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1;
        d_w = 1'($urandom_range(1));
        d_a = $urandom & 32'h0000_03FC;
        d_wd = $urandom;
      end
      rst_v = ($urandom_range(99) == 0);
      step();
    end
    rst_v = 0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
